// File: rtl/dma_mc_pkg.sv
// Shared types and default sizing for the DMA memory-controller responder.
package dma_mc_pkg;

    localparam int unsigned MC_DATA_W = 32;
    localparam int unsigned MC_ADDR_W = 6;
    localparam int unsigned MC_DEPTH  = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4,
        ST_ERR       = 3'd5
    } mc_state_e;

    // Reason for the most recent transition into ST_ERR (debug visibility).
    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_START  = 3'd1,
        ERR_ADDR_SKIP  = 3'd2,
        ERR_OVERFLOW   = 3'd3,
        ERR_WE_BUSY    = 3'd4,
        ERR_EARLY_DONE = 3'd5
    } mc_err_cause_e;

endpackage

// File: rtl/mc_buffer.sv
// Operand buffer: one synchronous write port, one asynchronous read port, no reset.
module mc_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store one word per enabled edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-controller end of the DMA link: buffers a write burst, then streams it to the PU.
module dma_mem_responder
    import dma_mc_pkg::*;
#(
    parameter int unsigned DATA_W = MC_DATA_W,
    parameter int unsigned ADDR_W = MC_ADDR_W,
    parameter int unsigned DEPTH  = MC_DEPTH
) (
    input  logic              mc_clk,
    input  logic              mc_reset,
    input  logic [ADDR_W-1:0] mc_data_address_in,
    input  logic              mc_we,
    input  logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_last,
    output logic              mc_err,
    output logic              mc_cont_procc,
    output logic              mc_data_done,
    output logic              mc_busy,
    output logic [DATA_W-1:0] pu_data,
    output logic              pu_valid,
    input  logic              pu_ready,
    input  logic              procc_done
);

    localparam int unsigned PW = ADDR_W + 1;

    mc_state_e     state, nstate;
    mc_err_cause_e cause_c;
    logic [PW-1:0] wptr, wptr_n, rptr, rptr_n, count, count_n;
    logic          wr_c, beat_c, last_beat_c;
    logic [DATA_W-1:0] rd_data;

    mc_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk   (mc_clk),
        .we    (wr_c),
        .waddr (mc_data_address_in),
        .wdata (mc_wdata),
        .raddr (rptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    // Next-state, pointer and write-enable decode; any error cause overrides to ST_ERR.
    always_comb begin
        nstate      = state;
        wptr_n      = wptr;
        rptr_n      = rptr;
        count_n     = count;
        wr_c        = 1'b0;
        cause_c     = ERR_NONE;
        beat_c      = (state == ST_STREAM) && pu_ready;
        last_beat_c = beat_c && (rptr == count - PW'(1));

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (mc_we) begin
                    if (mc_data_address_in == '0) begin
                        wr_c   = 1'b1;
                        wptr_n = PW'(1);
                        rptr_n = '0;
                        if (mc_last) begin
                            count_n = PW'(1);
                            nstate  = ST_STREAM;
                        end else begin
                            nstate  = ST_LOAD;
                        end
                    end else begin
                        cause_c = ERR_BAD_START;
                    end
                end else if (state == ST_DONE) begin
                    nstate = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (mc_we) begin
                    if ({1'b0, mc_data_address_in} != wptr) begin
                        cause_c = ERR_ADDR_SKIP;
                    end else begin
                        wr_c   = 1'b1;
                        wptr_n = wptr + PW'(1);
                        if (mc_last) begin
                            count_n = wptr + PW'(1);
                            nstate  = ST_STREAM;
                        end else if (wptr == PW'(DEPTH - 1)) begin
                            cause_c = ERR_OVERFLOW;
                        end
                    end
                end
            end
            ST_STREAM: begin
                if (mc_we) begin
                    cause_c = ERR_WE_BUSY;
                end else begin
                    if (beat_c) begin
                        rptr_n = rptr + PW'(1);
                    end
                    if (last_beat_c) begin
                        nstate = ST_WAIT_DONE;
                    end else if (procc_done) begin
                        cause_c = ERR_EARLY_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (mc_we) begin
                    cause_c = ERR_WE_BUSY;
                end else if (procc_done) begin
                    nstate = ST_DONE;
                end
            end
            default: nstate = ST_IDLE;
        endcase

        if (cause_c != ERR_NONE) begin
            nstate = ST_ERR;
        end
    end

    // State, pointers and registered output decode of the next state.
    always_ff @(posedge mc_clk or negedge mc_reset) begin
        if (!mc_reset) begin
            state         <= ST_IDLE;
            wptr          <= '0;
            rptr          <= '0;
            count         <= '0;
            mc_err        <= 1'b0;
            mc_cont_procc <= 1'b0;
            mc_data_done  <= 1'b0;
            mc_busy       <= 1'b0;
            pu_valid      <= 1'b0;
        end else begin
            state         <= nstate;
            wptr          <= wptr_n;
            rptr          <= rptr_n;
            count         <= count_n;
            mc_err        <= (nstate == ST_ERR);
            mc_cont_procc <= (nstate == ST_STREAM) || (nstate == ST_WAIT_DONE);
            mc_data_done  <= (nstate == ST_DONE);
            mc_busy       <= (nstate != ST_IDLE) && (nstate != ST_ERR);
            pu_valid      <= (nstate == ST_STREAM);
        end
    end

    // Buffer word is only presented while streaming; zero otherwise.
    assign pu_data = pu_valid ? rd_data : '0;

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder.
module tb_dma_mem_responder;

    logic        mc_clk;
    logic        mc_reset;
    logic [5:0]  mc_data_address_in;
    logic        mc_we;
    logic [31:0] mc_wdata;
    logic        mc_last;
    logic        mc_err;
    logic        mc_cont_procc;
    logic        mc_data_done;
    logic        mc_busy;
    logic [31:0] pu_data;
    logic        pu_valid;
    logic        pu_ready;
    logic        procc_done;

    int checks = 0;
    int errors = 0;

    dma_mem_responder dut (
        .mc_clk             (mc_clk),
        .mc_reset           (mc_reset),
        .mc_data_address_in (mc_data_address_in),
        .mc_we              (mc_we),
        .mc_wdata           (mc_wdata),
        .mc_last            (mc_last),
        .mc_err             (mc_err),
        .mc_cont_procc      (mc_cont_procc),
        .mc_data_done       (mc_data_done),
        .mc_busy            (mc_busy),
        .pu_data            (pu_data),
        .pu_valid           (pu_valid),
        .pu_ready           (pu_ready),
        .procc_done         (procc_done)
    );

    initial mc_clk = 1'b0;
    always #5 mc_clk = ~mc_clk;

    task automatic tick();
        @(posedge mc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic err, input logic cont,
                              input logic done, input logic busy, input logic valid,
                              input logic [31:0] data);
        chk({tag, ".err"},   {31'b0, mc_err},        {31'b0, err});
        chk({tag, ".cont"},  {31'b0, mc_cont_procc}, {31'b0, cont});
        chk({tag, ".done"},  {31'b0, mc_data_done},  {31'b0, done});
        chk({tag, ".busy"},  {31'b0, mc_busy},       {31'b0, busy});
        chk({tag, ".valid"}, {31'b0, pu_valid},      {31'b0, valid});
        chk({tag, ".data"},  pu_data,                data);
    endtask

    task automatic load_burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mc_we              = 1'b1;
            mc_data_address_in = 6'(i);
            mc_wdata           = base + 32'(i);
            mc_last            = (i == n - 1);
            tick();
        end
        mc_we   = 1'b0;
        mc_last = 1'b0;
    endtask

    task automatic finish_done(input string tag);
        procc_done = 1'b1;
        tick();
        check_outs({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        procc_done = 1'b0;
        tick();
        check_outs({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int idx;
        int c;
        mc_reset = 1'b1;
        mc_data_address_in = '0;
        mc_we = 1'b0;
        mc_wdata = '0;
        mc_last = 1'b0;
        pu_ready = 1'b0;
        procc_done = 1'b0;
        #1 mc_reset = 1'b0;
        #11;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mc_reset = 1'b1;
        tick();

        // 4-word burst, full throughput
        pu_ready = 1'b1;
        load_burst(4, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            check_outs("burst.beat", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0 + 32'(i));
            tick();
        end
        check_outs("burst.wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        finish_done("burst");

        // Backpressure with ready pattern 1,0,0,1,...
        load_burst(4, 32'hB0);
        idx = 0;
        c = 0;
        while (idx < 4 && c < 40) begin
            check_outs("bp.hold", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0 + 32'(idx));
            pu_ready = (c % 3 == 0);
            tick();
            if (pu_ready) idx++;
            c++;
        end
        check_outs("bp.wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        finish_done("bp");

        // Address skip 0,1,3
        mc_we = 1'b1; mc_last = 1'b0;
        mc_data_address_in = 6'd0; mc_wdata = 32'hC0;
        tick();
        check_outs("skip.load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        mc_data_address_in = 6'd1; mc_wdata = 32'hC1;
        tick();
        mc_data_address_in = 6'd3; mc_wdata = 32'hC3;
        tick();
        check_outs("skip.err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        mc_data_address_in = 6'd0; mc_wdata = 32'hC5; mc_last = 1'b1;
        tick();
        mc_we = 1'b0; mc_last = 1'b0; pu_ready = 1'b1;
        check_outs("skip.recover", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hC5);
        tick();
        check_outs("skip.wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        finish_done("skip");

        // Early completion after two of four beats
        load_burst(4, 32'hD0);
        tick();
        tick();
        check_outs("early.third", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hD2);
        pu_ready = 1'b0;
        procc_done = 1'b1;
        tick();
        check_outs("early.err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        procc_done = 1'b0;
        tick();
        check_outs("early.sticky", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Single-word burst then a write during STREAM
        load_burst(1, 32'hE0);
        check_outs("single.stream", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hE0);
        mc_we = 1'b1; mc_data_address_in = 6'd5; mc_wdata = 32'hE5;
        tick();
        mc_we = 1'b0;
        check_outs("single.we_err", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Overflow: 64 writes without last
        for (int i = 0; i < 64; i++) begin
            mc_we = 1'b1; mc_last = 1'b0;
            mc_data_address_in = 6'(i); mc_wdata = 32'(i);
            tick();
            if (i == 62) check_outs("ovf.62", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        mc_we = 1'b0;
        check_outs("ovf.63", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-STREAM
        load_burst(2, 32'h11);
        pu_ready = 1'b0;
        tick();
        check_outs("rst.pre", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11);
        #2 mc_reset = 1'b0;
        #1;
        check_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2 mc_reset = 1'b1;
        pu_ready = 1'b1;
        load_burst(3, 32'hF0);
        for (int i = 0; i < 3; i++) begin
            check_outs("post.beat", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF0 + 32'(i));
            tick();
        end
        check_outs("post.wait", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        finish_done("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
